// File: rtl/lisnoc_router_input_route.sv
// Router input port: one FWFT buffer per virtual channel, header destination
// decode through a static lookup table, and wormhole route hold until the tail flit.
module lisnoc_router_input_route #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int ph_dest_offset  = 27,
  parameter int num_dests       = 32,
  parameter int ports           = 5,
  parameter logic [num_dests*ports-1:0] lookup = '0,
  parameter int vchannels       = 1,
  parameter int fifo_length     = 4,
  localparam int flit_width     = flit_data_width + flit_type_width
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [flit_width-1:0]            link_flit,
  input  logic [vchannels-1:0]             link_valid,
  output logic [vchannels-1:0]             link_ready,
  output logic [vchannels*ports-1:0]       switch_request,
  output logic [vchannels*flit_width-1:0]  switch_flit,
  input  logic [vchannels*ports-1:0]       switch_read
);

  localparam int PW = (fifo_length > 1) ? $clog2(fifo_length) : 1;
  localparam int CW = $clog2(fifo_length + 1);

  localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = 2'b00;
  localparam logic [flit_type_width-1:0] TYPE_HEADER  = 2'b01;
  localparam logic [flit_type_width-1:0] TYPE_LAST    = 2'b10;
  localparam logic [flit_type_width-1:0] TYPE_SINGLE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(fifo_length - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [flit_width-1:0]      mem [fifo_length];
    logic [PW-1:0]              rd_ptr, wr_ptr;
    logic [CW-1:0]              count;
    logic                       push, pop, full, head_valid;
    logic [flit_width-1:0]      head;
    logic [flit_type_width-1:0] head_type;
    logic [ph_dest_width-1:0]   dest;
    logic                       dest_ok, is_hdr, is_end;
    logic [ports-1:0]           route, lut_route, req;
    state_t                     state;

    assign full       = (count == CW'(fifo_length));
    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign head_type  = head[flit_width-1 -: flit_type_width];
    assign dest       = head[ph_dest_offset +: ph_dest_width];
    assign dest_ok    = (int'(dest) < num_dests);
    assign lut_route  = dest_ok ? lookup[int'(dest)*ports +: ports] : '0;
    assign is_hdr     = (head_type == TYPE_HEADER) || (head_type == TYPE_SINGLE);
    assign is_end     = (head_type == TYPE_LAST) || (head_type == TYPE_SINGLE);

    assign link_ready[v] = ~rst & ~full;
    assign push          = link_valid[v] & link_ready[v];

    // A request is only presented while a routed packet has a flit at the head
    assign req = (state == ACTIVE && head_valid) ? route : '0;
    assign switch_request[v*ports +: ports]        = req;
    assign switch_flit[v*flit_width +: flit_width] = head_valid ? head : '0;

    always_comb begin
      pop = 1'b0;
      unique case (state)
        IDLE:    pop = head_valid & ~(is_hdr & dest_ok);
        ACTIVE:  pop = |(switch_read[v*ports +: ports] & req);
        DROP:    pop = head_valid;
        default: pop = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= link_flit;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // Unroutable headers enter DROP so the rest of their packet is discarded;
    // unroutable singles and stray body flits are discarded straight from IDLE.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        route <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (head_valid && is_hdr) begin
              if (dest_ok) begin
                route <= lut_route;
                state <= ACTIVE;
              end else if (head_type == TYPE_HEADER) begin
                state <= DROP;
              end
            end
          end
          ACTIVE: begin
            if (pop && is_end) begin
              route <= '0;
              state <= IDLE;
            end
          end
          DROP: begin
            if (pop && head_type == TYPE_LAST) state <= IDLE;
          end
          default: begin
            route <= '0;
            state <= IDLE;
          end
        endcase
      end
    end

    logic unused_payload_type;
    assign unused_payload_type = (TYPE_PAYLOAD != 2'b00);
  end

endmodule

// File: tb/tb_lisnoc_router_input_route.sv
// Bench for lisnoc_router_input_route: directed scenarios followed by random
// traffic on two vchannels against a packet-level reference model.
module tb_lisnoc_router_input_route;

  localparam int V  = 2;
  localparam int P  = 5;
  localparam int FW = 34;
  localparam int ND = 32;

  localparam logic [1:0] PAY = 2'b00;
  localparam logic [1:0] HDR = 2'b01;
  localparam logic [1:0] LST = 2'b10;
  localparam logic [1:0] SGL = 2'b11;

  function automatic logic [ND*P-1:0] build_lut();
    logic [ND*P-1:0] l;
    l = '0;
    for (int d = 0; d < ND; d++) l[d*P +: P] = 5'(1 << (d % P));
    l[0*P +: P] = 5'b00001;
    l[3*P +: P] = 5'b00100;
    return l;
  endfunction

  localparam logic [ND*P-1:0] LUT = build_lut();

  logic              clk = 1'b0;
  logic              rst;
  logic [FW-1:0]     link_flit;
  logic [V-1:0]      link_valid;
  logic [V-1:0]      link_ready;
  logic [V*P-1:0]    switch_request;
  logic [V*FW-1:0]   switch_flit;
  logic [V*P-1:0]    switch_read;

  lisnoc_router_input_route #(
    .flit_data_width (32),
    .flit_type_width (2),
    .ph_dest_width   (6),
    .ph_dest_offset  (26),
    .num_dests       (ND),
    .ports           (P),
    .lookup          (LUT),
    .vchannels       (V),
    .fifo_length     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .link_flit      (link_flit),
    .link_valid     (link_valid),
    .link_ready     (link_ready),
    .switch_request (switch_request),
    .switch_flit    (switch_flit),
    .switch_read    (switch_read)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [5:0] d, input logic [31:0] x);
    return {t, d, x[25:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    link_valid  = '0;
    switch_read = '0;
    link_flit   = '0;
    rst = 1'b1;
    #2;
    check("rst_ready", link_ready, 2'b00);
    check("rst_req", switch_request, '0);
    check("rst_flit", switch_flit, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_ready", link_ready, 2'b11);
  endtask

  // Reference model state for the random phase
  logic [FW-1:0] mq_flit  [V][$];
  logic [P-1:0]  mq_fate  [V][$];
  bit            mq_first [V][$];
  logic [FW-1:0] pend     [V][$];
  bit            decoded  [V];
  bit            in_pkt   [V];
  logic [P-1:0]  cur_fate [V];

  // Decide the fate of each accepted flit from the packet it belongs to:
  // a route for flits of routable packets, 0 for anything that is discarded.
  task automatic classify(input int v, input logic [FW-1:0] f,
                          output logic [P-1:0] fate, output bit first);
    logic [1:0] t;
    int d;
    t = f[33:32];
    d = int'(f[31:26]);
    first = 1'b0;
    if (!in_pkt[v]) begin
      if (t == HDR || t == SGL) begin
        fate  = (d < ND) ? LUT[d*P +: P] : '0;
        first = (fate != '0);
        if (t == HDR) begin
          in_pkt[v]   = 1'b1;
          cur_fate[v] = fate;
        end
      end else begin
        fate = '0;
      end
    end else begin
      fate = cur_fate[v];
      if (t == LST) in_pkt[v] = 1'b0;
    end
  endtask

  task automatic gen_packet(input int v);
    int r, n;
    r = $urandom_range(0, 9);
    if (r < 5 || r == 7) begin
      pend[v].push_back(mk(HDR, (r < 5) ? 6'($urandom_range(0, 31)) : 6'($urandom_range(32, 63)), $urandom));
      n = $urandom_range(0, 3);
      repeat (n) pend[v].push_back(mk(PAY, 6'($urandom), $urandom));
      pend[v].push_back(mk(LST, 6'($urandom), $urandom));
    end else if (r < 7) begin
      pend[v].push_back(mk(SGL, 6'($urandom_range(0, 31)), $urandom));
    end else if (r == 8) begin
      pend[v].push_back(mk(SGL, 6'($urandom_range(32, 63)), $urandom));
    end else begin
      pend[v].push_back(mk($urandom_range(0, 1) ? LST : PAY, 6'($urandom), $urandom));
    end
  endtask

  initial begin
    logic [FW-1:0] f [5];
    logic [FW-1:0] got [$];
    logic [FW-1:0] s, h1, l1;
    logic [P-1:0]  ereq [V];
    bit            erdy [V];
    bit            popq;
    logic [P-1:0]  fate;
    bit            first;
    int            sel, r;

    // Single-packet routing with the read held on the routed output
    do_reset();
    f[0] = mk(HDR, 6'd3, $urandom);
    f[1] = mk(PAY, 6'($urandom), $urandom);
    f[2] = mk(PAY, 6'($urandom), $urandom);
    f[3] = mk(LST, 6'($urandom), $urandom);
    switch_read = 10'b00000_00100;
    for (int k = 0; k <= 6; k++) begin
      if (k < 4) begin link_valid = 2'b01; link_flit = f[k]; end
      else link_valid = 2'b00;
      check("route_req", switch_request[4:0], (k >= 2 && k <= 5) ? 5'b00100 : 5'b00000);
      if (k >= 2 && k <= 5) check("route_flit", switch_flit[33:0], f[k-2]);
      tick();
    end

    // Backpressure: fill the FIFO, then free one slot
    do_reset();
    for (int k = 0; k < 5; k++)
      f[k] = (k == 0) ? mk(HDR, 6'd3, $urandom) : (k == 4) ? mk(LST, 6'($urandom), $urandom)
                                                           : mk(PAY, 6'($urandom), $urandom);
    for (int k = 0; k < 5; k++) begin
      link_valid = 2'b01;
      link_flit  = f[k];
      check("bp_ready", link_ready[0], (k < 4) ? 1'b1 : 1'b0);
      tick();
    end
    check("bp_full_ready", link_ready[0], 1'b0);
    switch_read = 10'b00000_00100;
    tick();
    switch_read = '0;
    check("bp_ready_back", link_ready[0], 1'b1);
    tick();
    link_valid  = '0;
    switch_read = 10'b00000_00100;
    got.delete();
    for (int i = 0; i < 12 && got.size() < 4; i++) begin
      if (switch_request[4:0] != '0) got.push_back(switch_flit[33:0]);
      tick();
    end
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], f[i+1]);
    check("bp_req_end", switch_request[4:0], 5'b00000);

    // Unroutable destination and stray payload, all with every read bit up
    do_reset();
    switch_read = '1;
    f[0] = mk(HDR, 6'd40, $urandom);
    f[1] = mk(PAY, 6'($urandom), $urandom);
    f[2] = mk(LST, 6'($urandom), $urandom);
    f[3] = mk(PAY, 6'($urandom), $urandom);
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin link_valid = 2'b01; link_flit = f[k]; end
      else link_valid = 2'b00;
      check("drop_req", switch_request, '0);
      tick();
    end
    check("drop_ready", link_ready, 2'b11);

    // Read filtering: wrong output bits must not pop the single
    switch_read = '0;
    s = mk(SGL, 6'd3, $urandom);
    for (int k = 0; k <= 6; k++) begin
      link_valid  = (k == 0) ? 2'b01 : 2'b00;
      link_flit   = s;
      switch_read = (k >= 2 && k <= 4) ? 10'b00000_00001 : (k == 5) ? 10'b00000_00100 : 10'b0;
      check("filt_req", switch_request[4:0], (k >= 2 && k <= 5) ? 5'b00100 : 5'b00000);
      if (k >= 2 && k <= 5) check("filt_flit", switch_flit[33:0], s);
      tick();
    end
    check("filt_ready", link_ready[0], 1'b1);

    // Asynchronous reset in the middle of a packet
    do_reset();
    link_valid = 2'b01; link_flit = mk(HDR, 6'd3, $urandom); tick();
    link_flit = mk(PAY, 6'($urandom), $urandom); tick();
    link_valid = '0;
    check("mid_req_before", switch_request[4:0], 5'b00100);
    #2;
    rst = 1'b1;
    #1;
    check("mid_req_rst", switch_request, '0);
    check("mid_ready_rst", link_ready, 2'b00);
    check("mid_flit_rst", switch_flit, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_ready_after", link_ready, 2'b11);
    h1 = mk(HDR, 6'd3, $urandom);
    l1 = mk(LST, 6'($urandom), $urandom);
    switch_read = 10'b00000_00100;
    for (int k = 0; k <= 4; k++) begin
      link_valid = (k < 2) ? 2'b01 : 2'b00;
      link_flit  = (k == 0) ? h1 : l1;
      check("mid_new_req", switch_request[4:0], (k == 2 || k == 3) ? 5'b00100 : 5'b00000);
      if (k == 2) check("mid_new_hdr", switch_flit[33:0], h1);
      if (k == 3) check("mid_new_last", switch_flit[33:0], l1);
      tick();
    end

    // Two independent vchannels, v0 stalled
    do_reset();
    f[0] = mk(HDR, 6'd3, $urandom);
    f[1] = mk(PAY, 6'($urandom), $urandom);
    f[2] = mk(LST, 6'($urandom), $urandom);
    h1 = mk(HDR, 6'd0, $urandom);
    l1 = mk(LST, 6'($urandom), $urandom);
    switch_read = 10'b00001_00000;
    for (int k = 0; k <= 7; k++) begin
      link_valid = '0;
      case (k)
        0: begin link_valid = 2'b01; link_flit = f[0]; end
        1: begin link_valid = 2'b10; link_flit = h1;   end
        2: begin link_valid = 2'b01; link_flit = f[1]; end
        3: begin link_valid = 2'b10; link_flit = l1;   end
        4: begin link_valid = 2'b01; link_flit = f[2]; end
        default: ;
      endcase
      check("vc1_req", switch_request[9:5], (k == 3 || k == 4) ? 5'b00001 : 5'b00000);
      if (k == 3) check("vc1_hdr", switch_flit[67:34], h1);
      if (k == 4) check("vc1_last", switch_flit[67:34], l1);
      check("vc0_req_held", switch_request[4:0], (k >= 2) ? 5'b00100 : 5'b00000);
      tick();
    end
    switch_read = 10'b00000_00100;
    got.delete();
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (switch_request[4:0] != '0) got.push_back(switch_flit[33:0]);
      tick();
    end
    check("vc0_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("vc0_order", got[i], f[i]);

    // Random traffic against the reference model
    do_reset();
    for (int v = 0; v < V; v++) begin
      mq_flit[v].delete(); mq_fate[v].delete(); mq_first[v].delete(); pend[v].delete();
      decoded[v] = 1'b0; in_pkt[v] = 1'b0; cur_fate[v] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int v = 0; v < V; v++) begin
        erdy[v] = (mq_flit[v].size() < 4);
        ereq[v] = '0;
        if (mq_flit[v].size() > 0 && mq_fate[v][0] != '0 && (!mq_first[v][0] || decoded[v]))
          ereq[v] = mq_fate[v][0];
        check("rnd_ready", link_ready[v], erdy[v]);
        check("rnd_req", switch_request[v*P +: P], ereq[v]);
        if (mq_flit[v].size() > 0) check("rnd_flit", switch_flit[v*FW +: FW], mq_flit[v][0]);
      end
      sel = $urandom_range(0, V - 1);
      link_valid = '0;
      if (pend[sel].size() == 0) gen_packet(sel);
      if ($urandom_range(0, 9) < 7) begin
        link_valid[sel] = 1'b1;
        link_flit = pend[sel][0];
      end
      for (int v = 0; v < V; v++) begin
        r = $urandom_range(0, 3);
        switch_read[v*P +: P] = (r == 0) ? 5'b0 : (r == 1) ? 5'($urandom) : ereq[v];
      end
      @(posedge clk);
      for (int v = 0; v < V; v++) begin
        popq = 1'b0;
        if (mq_flit[v].size() > 0) begin
          popq = (mq_fate[v][0] == '0) || ((switch_read[v*P +: P] & ereq[v]) != '0);
          if (mq_first[v][0] && mq_fate[v][0] != '0 && !decoded[v]) decoded[v] = 1'b1;
        end
        if (popq) begin
          if (mq_first[v][0]) decoded[v] = 1'b0;
          void'(mq_flit[v].pop_front());
          void'(mq_fate[v].pop_front());
          void'(mq_first[v].pop_front());
        end
        if (link_valid[v] && erdy[v]) begin
          classify(v, link_flit, fate, first);
          mq_flit[v].push_back(link_flit);
          mq_fate[v].push_back(fate);
          mq_first[v].push_back(first);
          void'(pend[v].pop_front());
        end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lisnoc_router_input_route.md
Name: lisnoc_router_input_route

Overview:
- Router input port: one per link direction, directly upstream of the switch and the output ports.
- Accepts flits from an incoming link into one buffer FIFO per virtual channel.
- Decodes the destination in each packet header through a static lookup table and holds a one-hot output-port request per vchannel for the whole wormhole packet.
- Pops one flit per switch_read; releases the route on the tail flit.

Parameters:
- flit_data_width, 32, data bits per flit
- flit_type_width, 2, type bits per flit; flit_width = sum of the two
- ph_dest_width, 5, destination field width in header
- ph_dest_offset, 27, LSB position of the destination field within the data bits
- num_dests, 32, number of routable destinations
- lookup, all zeros, num_dests*ports bits; bits [d*ports +: ports] are the one-hot output port for destination d
- vchannels, 1, number of virtual channels
- ports, 5, number of switch output ports
- fifo_length, 4, input FIFO depth per vchannel (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- link_flit  in  flit_width  incoming flit, shared by all vchannels
- link_valid  in  vchannels  flit valid for vchannel v
- link_ready  out  vchannels  vchannel v FIFO can accept a flit
- switch_request  out  vchannels*ports  bit v*ports+p: vchannel v requests output p
- switch_flit  out  vchannels*flit_width  FIFO head flit of vchannel v
- switch_read  in  vchannels*ports  bit v*ports+p: output p consumed vchannel v's head flit

Behaviour:
- Flit type is held in the top type bits: PAYLOAD 2'b00, HEADER 2'b01, LAST 2'b10, SINGLE 2'b11.
- Link side:
  - link_ready[v] = FIFO v not full; the combinational signal is valid in the same cycle.
  - A write occurs when link_valid[v] and link_ready[v] are both high.
  - Asserting more than one link_valid bit in a cycle is illegal; it is not checked.
- FIFO:
  - Registered; first-word-fall-through one cycle after the write.
  - A simultaneous push and pop on a full FIFO is legal and keeps the occupancy constant.
- Per-vchannel FSM, states IDLE, ACTIVE, DROP:
  - IDLE, head valid, type HEADER or SINGLE, dest < num_dests: register route = lookup[dest*ports +: ports] and go to ACTIVE. No pop.
  - IDLE, head valid, type HEADER, dest >= num_dests: pop the head and go to DROP.
  - IDLE, head valid, type SINGLE, dest >= num_dests: pop the head and stay in IDLE.
  - IDLE, head PAYLOAD or LAST (protocol error): pop the head and stay in IDLE.
  - ACTIVE: switch_request[v*ports +: ports] = route when the head is valid, otherwise 0. Any switch_read bit in that slice matching route pops the head. If the popped flit is LAST or SINGLE, return to IDLE and clear route; the request drops in the next cycle.
  - DROP: pop each head flit; on LAST, return to IDLE.
- Read filtering: switch_read bits that do not match a current request are ignored and cause no pop.
- A lookup entry of all zeros means "no route". The packet then stalls in ACTIVE with no request. This is the documented configuration error.
- switch_flit[v] always shows the FIFO head; it is don't-care when the head is not valid.
- Latency: a header written at cycle n is at the FIFO head at n+1, and switch_request is high at n+2. Following flits are forwarded back to back, one per cycle, given reads.
- Vchannels are fully independent; no cross-vchannel state.
- Reset (asynchronous, including mid-packet):
  - FIFOs empty, FSMs IDLE, route 0.
  - switch_request 0, link_ready 0 while rst is high, then all 1.
  - switch_flit 0.
- Implementation: 150-300 RTL lines, with the FIFO inline or reusing the team FIFO.

Test Plan:
- Setup for all cases: vchannels=1, ports=5, lookup[3]=5'b00100.
- Single-packet routing:
  - Stimulus: HEADER dest 3, two PAYLOAD, LAST, with switch_read[2]=1 from cycle 2.
  - Response: switch_request=5'b00100 from cycle 2 for exactly 4 cycles; flits emerge in order; FSM returns to IDLE; request 0 at cycle 6.
- Backpressure and full FIFO:
  - Stimulus: write 5 flits with switch_read=0.
  - Response: link_ready goes low after 4 writes; the fifth flit is held. Asserting read once gives link_ready=1 in the next cycle; no flit is lost or duplicated.
- Unroutable destination and protocol error:
  - Stimulus: HEADER dest 40 (with num_dests=32), PAYLOAD, LAST; then a lone PAYLOAD.
  - Response: all four flits are dropped; switch_request stays 0 throughout; link_ready recovers.
- Read filtering:
  - Stimulus: SINGLE dest 3 with switch_read=5'b00001 for 3 cycles, then 5'b00100.
  - Response: no pop during the wrong reads; the flit pops on the 5'b00100 cycle; FSM IDLE afterwards.
- Reset mid-packet:
  - Stimulus: assert rst asynchronously after HEADER+PAYLOAD are accepted.
  - Response: outputs 0 immediately; after release, a new HEADER dest 3 routes with the normal 2-cycle latency and no stale flits.
- Two vchannels (vchannels=2):
  - Stimulus: interleave packets on v0 (dest 3) and v1 (dest 0, lookup[0]=5'b00001); stall v0 reads.
  - Response: v1 completes independently; v0 request is held until read.
